// File: rtl/dmem_arbiter_pkg.sv
// Shared types and encodings for the data-memory arbiter.
// Imported by the arbiter top and its starvation counter.
package dmem_arbiter_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating count of arbitration rounds debug has lost to the CPU.
// at_max tells the arbiter to hand the next contended round to debug.
module arb_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [WAIT_W-1:0] cnt,
    output logic              at_max
);

    localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX_WAIT);

    assign at_max = (cnt == MAX_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the CPU memory stage and a
// debug/loader port; each access runs grant -> issue -> response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] cpu_address,
    input  logic [WIDTH-1:0] cpu_write_data,
    output logic [WIDTH-1:0] cpu_read_data,
    output logic             cpu_done,
    output logic             cpu_stall,
    input  logic             dbg_valid,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_address,
    input  logic [WIDTH-1:0] dbg_write_data,
    output logic             dbg_ready,
    output logic [WIDTH-1:0] dbg_read_data,
    output logic             dbg_rvalid,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_read_data
);

    state_t            state;
    owner_t            owner;
    logic              lat_we;
    logic              lat_both;
    logic [WIDTH-1:0]  lat_addr;
    logic [WIDTH-1:0]  lat_wdata;
    logic [WIDTH-1:0]  cpu_rdata_q;
    logic [WIDTH-1:0]  dbg_rdata_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              at_max;
    logic              cpu_req;
    logic              idle;
    logic              dbg_win;
    logic              cpu_win;

    assign cpu_req = MemRead | MemWrite;
    assign idle    = (state == IDLE);
    assign dbg_win = idle & dbg_valid & (~cpu_req | at_max);
    assign cpu_win = idle & cpu_req & ~dbg_win;

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (cpu_win & dbg_valid),
        .clr    (dbg_win),
        .cnt    (wait_cnt),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            lat_we      <= 1'b0;
            lat_both    <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        dbg_win: begin
                            owner     <= OWN_DBG;
                            lat_we    <= dbg_we;
                            lat_both  <= 1'b0;
                            lat_addr  <= dbg_address;
                            lat_wdata <= dbg_write_data;
                            state     <= ISSUE;
                        end
                        cpu_win: begin
                            owner     <= OWN_CPU;
                            lat_we    <= MemWrite;
                            lat_both  <= MemRead & MemWrite;
                            lat_addr  <= cpu_address;
                            lat_wdata <= cpu_write_data;
                            state     <= ISSUE;
                        end
                        default: state <= IDLE;
                    endcase
                end
                ISSUE: state <= RESP;
                RESP: begin
                    if (!lat_we) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata_q <= mem_read_data;
                        end else begin
                            dbg_rdata_q <= mem_read_data;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_ready      = dbg_win;
    assign mem_read       = (state == ISSUE) & ~lat_we;
    assign mem_write      = (state == ISSUE) & lat_we;
    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;
    assign cpu_done       = (state == RESP) & (owner == OWN_CPU);
    assign dbg_rvalid     = (state == RESP) & (owner == OWN_DBG);
    assign cpu_stall      = cpu_req & ~cpu_done;

    // Load data is forwarded during the done pulse, then held.
    always_comb begin
        cpu_read_data = cpu_rdata_q;
        if (cpu_done) begin
            if (lat_both) begin
                cpu_read_data = '0;
            end else if (!lat_we) begin
                cpu_read_data = mem_read_data;
            end
        end
    end

    assign dbg_read_data = (dbg_rvalid & ~lat_we) ? mem_read_data
                                                  : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a
// transaction-level arbitration and memory reference model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int W  = 32;
    localparam int MW = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         MemRead, MemWrite;
    logic [W-1:0] cpu_address, cpu_write_data, cpu_read_data;
    logic         cpu_done, cpu_stall;
    logic         dbg_valid, dbg_we, dbg_ready, dbg_rvalid;
    logic [W-1:0] dbg_address, dbg_write_data, dbg_read_data;
    logic         mem_read, mem_write;
    logic [W-1:0] mem_address, mem_write_data;
    logic [W-1:0] mem_read_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(W), .MAX_WAIT(MW), .WAIT_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read_data  (cpu_read_data),
        .cpu_done       (cpu_done),
        .cpu_stall      (cpu_stall),
        .dbg_valid      (dbg_valid),
        .dbg_we         (dbg_we),
        .dbg_address    (dbg_address),
        .dbg_write_data (dbg_write_data),
        .dbg_ready      (dbg_ready),
        .dbg_read_data  (dbg_read_data),
        .dbg_rvalid     (dbg_rvalid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    function automatic logic [W-1:0] seed(int i);
        return (i == 4) ? 32'h0000_DEAD : (32'h1000_0000 | 32'(i * 273));
    endfunction

    // Environment: data_mem with one-cycle read latency.
    logic [W-1:0] dm [16];
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) dm[i] <= seed(i);
            mem_read_data <= '0;
        end else begin
            if (mem_write) dm[mem_address[5:2]] <= mem_write_data;
            if (mem_read) mem_read_data <= dm[mem_address[5:2]];
        end
    end

    typedef struct {
        bit           dbg;
        bit           we;
        bit           both;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        int           done_cyc;
    } txn_t;

    txn_t         sbq [$];
    logic [W-1:0] ref_mem [16];
    int           ref_wait;
    int           busy;
    int           cyc;
    int           checks;
    int           errors;
    bit           cpu_done_s;
    bit           dbg_ready_s;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge clk) begin
        txn_t t;
        bit   creq, dwin, cwin;
        int   idx;
        cyc++;
        cpu_done_s  = cpu_done;
        dbg_ready_s = dbg_ready;
        if (reset) begin
            sbq.delete();
            busy     = 0;
            ref_wait = 0;
        end else begin
            chk("wait_cnt", 32'(dut.wait_cnt), 32'(ref_wait));
            if (mem_read || mem_write) begin
                if (sbq.size() == 0) fail("unexpected_mem_strobe");
                else begin
                    chk("mem_write", 32'(mem_write), 32'(sbq[0].we));
                    chk("mem_read", 32'(mem_read), 32'(!sbq[0].we));
                    chk("mem_address", mem_address, sbq[0].addr);
                    if (sbq[0].we) chk("mem_write_data", mem_write_data, sbq[0].wdata);
                    chk("issue_cycle", 32'(cyc), 32'(sbq[0].done_cyc - 1));
                end
            end
            if (cpu_done || dbg_rvalid) begin
                if (sbq.size() == 0) fail("unexpected_done");
                else begin
                    t = sbq.pop_front();
                    chk("done_owner", 32'(dbg_rvalid), 32'(t.dbg));
                    chk("done_exclusive", 32'(cpu_done & dbg_rvalid), 32'(0));
                    chk("done_cycle", 32'(cyc), 32'(t.done_cyc));
                    if (!t.dbg && (!t.we || t.both))
                        chk("cpu_read_data", cpu_read_data, t.rdata);
                    if (t.dbg && !t.we)
                        chk("dbg_read_data", dbg_read_data, t.rdata);
                end
            end
            if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
                fail("done_timeout");
                void'(sbq.pop_front());
            end
            creq = MemRead || MemWrite;
            chk("cpu_stall", 32'(cpu_stall), 32'(creq && !cpu_done));
            if (busy > 0) begin
                busy--;
                chk("dbg_ready_busy", 32'(dbg_ready), 32'(0));
            end else begin
                dwin = dbg_valid && (!creq || ref_wait >= MW);
                cwin = creq && !dwin;
                chk("dbg_ready", 32'(dbg_ready), 32'(dwin));
                if (dwin || cwin) begin
                    t.dbg      = dwin;
                    t.we       = dwin ? dbg_we : MemWrite;
                    t.both     = cwin && MemRead && MemWrite;
                    t.addr     = dwin ? dbg_address : cpu_address;
                    t.wdata    = dwin ? dbg_write_data : cpu_write_data;
                    idx        = int'(t.addr[5:2]);
                    t.rdata    = t.both ? '0 : ref_mem[idx];
                    t.done_cyc = cyc + 2;
                    if (t.we) ref_mem[idx] = t.wdata;
                    sbq.push_back(t);
                    busy = 2;
                end
                if (dwin) ref_wait = 0;
                else if (cwin && dbg_valid && ref_wait < MW) ref_wait++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; dbg_valid = 0; dbg_we = 0;
        cpu_address = '0; cpu_write_data = '0;
        dbg_address = '0; dbg_write_data = '0;
    endtask

    task automatic cpu_driver(int ncyc);
        bit active = 0;
        int op;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (active && cpu_done_s) begin
                active = 0; MemRead = 0; MemWrite = 0;
            end
            if (!active && $urandom_range(0, 2) == 0) begin
                op = int'($urandom_range(0, 5));
                MemRead  = (op <= 2) || (op == 5);
                MemWrite = (op >= 3);
                cpu_address    = 32'($urandom_range(0, 15)) << 2;
                cpu_write_data = $urandom;
                active = 1;
            end
        end
        MemRead = 0; MemWrite = 0;
    endtask

    task automatic dbg_driver(int ncyc);
        bit active = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (active && dbg_ready_s) begin
                active = 0; dbg_valid = 0;
            end else if (active && $urandom_range(0, 15) == 0) begin
                active = 0; dbg_valid = 0;
            end
            if (!active && $urandom_range(0, 3) == 0) begin
                dbg_valid      = 1;
                dbg_we         = 1'($urandom_range(0, 1));
                dbg_address    = 32'($urandom_range(0, 15)) << 2;
                dbg_write_data = $urandom;
                active = 1;
            end
        end
        dbg_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ncpu;
        bit  got;
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = seed(i);
        idle_inputs();
        reset = 1; load = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0; load = 0;

        @(negedge clk);
        chk("rst_mem_read", 32'(mem_read), 32'(0));
        chk("rst_mem_write", 32'(mem_write), 32'(0));
        chk("rst_cpu_done", 32'(cpu_done), 32'(0));
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
        chk("rst_dbg_ready", 32'(dbg_ready), 32'(0));
        chk("rst_mem_address", mem_address, 32'(0));
        chk("rst_mem_write_data", mem_write_data, 32'(0));
        chk("rst_cpu_read_data", cpu_read_data, 32'(0));
        chk("rst_dbg_read_data", dbg_read_data, 32'(0));
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // CPU load of 0xDEAD from 0x10
        tick();
        MemRead = 1; cpu_address = 32'h10;
        @(negedge clk);
        chk("t1_stall_c0", 32'(cpu_stall), 32'(1));
        @(negedge clk);
        chk("t1_mem_read_c1", 32'(mem_read), 32'(1));
        chk("t1_stall_c1", 32'(cpu_stall), 32'(1));
        @(negedge clk);
        chk("t1_done_c2", 32'(cpu_done), 32'(1));
        chk("t1_rdata_c2", cpu_read_data, 32'h0000_DEAD);
        chk("t1_stall_c2", 32'(cpu_stall), 32'(0));
        tick();
        MemRead = 0;

        // Debug store 0x55 to 0x20
        dbg_valid = 1; dbg_we = 1; dbg_address = 32'h20; dbg_write_data = 32'h55;
        @(negedge clk);
        chk("t2_ready_c0", 32'(dbg_ready), 32'(1));
        tick();
        dbg_valid = 0;
        @(negedge clk);
        chk("t2_mem_write_c1", 32'(mem_write), 32'(1));
        chk("t2_addr_c1", mem_address, 32'h20);
        chk("t2_wdata_c1", mem_write_data, 32'h55);
        @(negedge clk);
        chk("t2_rvalid_c2", 32'(dbg_rvalid), 32'(1));
        tick();

        // MemRead and MemWrite together behave as a write
        MemRead = 1; MemWrite = 1; cpu_address = 32'h30; cpu_write_data = 32'h77;
        @(negedge clk);
        @(negedge clk);
        chk("t3_mem_write", 32'(mem_write), 32'(1));
        chk("t3_mem_read", 32'(mem_read), 32'(0));
        @(negedge clk);
        chk("t3_done", 32'(cpu_done), 32'(1));
        chk("t3_rdata_zero", cpu_read_data, 32'(0));
        tick();
        MemRead = 0; MemWrite = 0;

        // Contention: debug gets the grant after MAX_WAIT CPU wins
        MemRead = 1; cpu_address = 32'h0;
        dbg_valid = 1; dbg_we = 0; dbg_address = 32'h4;
        ncpu = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cpu_done) ncpu++;
            if (dbg_ready) got = 1;
        end
        if (!got) fail("t4_dbg_never_granted");
        chk("t4_cpu_wins", 32'(ncpu), 32'(MW));
        tick();
        MemRead = 0; dbg_valid = 0;
        repeat (3) tick();
        chk("t4_wait_cnt_cleared", 32'(dut.wait_cnt), 32'(0));

        // Reset during ISSUE of a CPU read
        MemRead = 1; cpu_address = 32'h8;
        tick();
        reset = 1; MemRead = 0;
        tick();
        reset = 0;
        @(negedge clk);
        chk("t5_state", 32'(dut.state), 32'(IDLE));
        chk("t5_mem_read", 32'(mem_read), 32'(0));
        chk("t5_mem_write", 32'(mem_write), 32'(0));
        chk("t5_cpu_done", 32'(cpu_done), 32'(0));
        chk("t5_dbg_rvalid", 32'(dbg_rvalid), 32'(0));
        @(negedge clk);
        chk("t5_cpu_done_late", 32'(cpu_done), 32'(0));
        chk("t5_dbg_rvalid_late", 32'(dbg_rvalid), 32'(0));
        tick();

        // Debug pulse while CPU owns the port, dropped before IDLE
        MemRead = 1; cpu_address = 32'hC;
        dbg_valid = 1; dbg_we = 1; dbg_address = 32'h3C; dbg_write_data = 32'h99;
        tick();
        tick();
        dbg_valid = 0;
        tick();
        MemRead = 0;
        ncpu = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dbg_rvalid || dbg_ready || mem_write) ncpu++;
        end
        chk("t6_no_dbg_access", 32'(ncpu), 32'(0));
        chk("t6_wait_cnt_kept", 32'(dut.wait_cnt), 32'(1));
        tick();

        // Randomized traffic from both requesters
        fork
            cpu_driver(3000);
            dbg_driver(3000);
        join
        idle_inputs();
        repeat (6) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
